// File: rtl/sram_burst_reader_if.sv
// Command, output-stream and SRAM burst-port signals of the burst reader.
// master: the reader itself. slave: its environment (command source,
// consumer and SRAM controller).
interface sram_burst_reader_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        abort;
  logic        cmd_done;
  logic        busy;

  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;

  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [7:0]  mem_burst_len;
  logic        mem_ready;
  logic        mem_burst_data_valid;
  logic [15:0] mem_rdata_16;
  logic        mem_burst_done;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, abort, out_ready,
           mem_ready, mem_burst_data_valid, mem_rdata_16, mem_burst_done,
    output cmd_ready, cmd_done, busy, out_valid, out_data, out_last,
           mem_req, mem_we, mem_addr, mem_burst_len
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, abort, out_ready,
           mem_ready, mem_burst_data_valid, mem_rdata_16, mem_burst_done,
    input  cmd_ready, cmd_done, busy, out_valid, out_data, out_last,
           mem_req, mem_we, mem_addr, mem_burst_len
  );
endinterface

// File: rtl/sram_burst_reader.sv
// Burst-read initiator: splits a (start, length) read command into bursts of
// at most MAX_BURST words and streams the returned words, in command order,
// through a first-word-fall-through FIFO. A burst cancelled early by the
// arbiter is resumed at the first word not yet received.
//
// state      | meaning
// IDLE       | waiting for a command
// WAIT_SPACE | waiting until the FIFO can absorb the whole next chunk
// REQ        | burst request held until the controller accepts it
// XFER       | receiving beats of the granted burst
// DRAIN      | aborted mid-burst; swallowing beats until the burst ends
module sram_burst_reader #(
  parameter int MAX_BURST  = 255,
  parameter int FIFO_DEPTH = 256
) (
  input logic                 clk,
  input logic                 rst_n,
  sram_burst_reader_if.master bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] MAX_LEN = 16'(MAX_BURST);

  typedef enum logic [2:0] {IDLE, WAIT_SPACE, REQ, XFER, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [23:0]   cur_addr;
  logic [15:0]   remaining, remaining_upd;
  logic [7:0]    beats, req_len, chunk;
  logic [CW-1:0] count, free_words;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [16:0]   fifo_mem [FIFO_DEPTH];
  logic          cmd_ready, mem_req, accept, beat_ok, pop;
  logic          cmd_done_q, cmd_done_nxt;

  assign chunk         = (remaining >= MAX_LEN) ? MAX_LEN[7:0] : remaining[7:0];
  assign free_words    = CW'(FIFO_DEPTH) - count;
  assign accept        = bus.cmd_valid && cmd_ready;
  // Beats beyond the granted length are never stored, so the space reserved
  // in WAIT_SPACE always covers everything that is pushed.
  assign beat_ok       = (state == XFER) && bus.mem_burst_data_valid && !bus.abort
                         && (beats < req_len);
  assign pop           = bus.out_ready && (count != '0);
  assign remaining_upd = beat_ok ? remaining - 16'd1 : remaining;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, handshake outputs and completion pulse.
  always_comb begin
    state_nxt    = state;
    cmd_ready    = 1'b0;
    mem_req      = 1'b0;
    cmd_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !bus.abort;
        if (bus.cmd_valid && !bus.abort) begin
          if (bus.cmd_len != 16'd0) state_nxt = WAIT_SPACE;
          else                      cmd_done_nxt = 1'b1;
        end
      end
      WAIT_SPACE: if (32'(free_words) >= 32'(chunk)) state_nxt = REQ;
      REQ: begin
        mem_req = 1'b1;
        if (bus.mem_ready) state_nxt = XFER;
      end
      XFER: begin
        // A beat in the same cycle as done has already been counted in
        // remaining_upd, so a cancel on the final beat still completes.
        if (bus.mem_burst_done) begin
          if (remaining_upd == 16'd0) begin
            state_nxt    = IDLE;
            cmd_done_nxt = 1'b1;
          end else begin
            state_nxt = WAIT_SPACE;
          end
        end
      end
      DRAIN: if (bus.mem_burst_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.abort) begin
      mem_req      = 1'b0;
      cmd_done_nxt = 1'b0;
      if ((state == XFER || state == DRAIN) && !bus.mem_burst_done) state_nxt = DRAIN;
      else                                                           state_nxt = IDLE;
    end
  end

  // Command progress: address, words left, beats of the current burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr   <= '0;
      remaining  <= '0;
      beats      <= '0;
      req_len    <= '0;
      cmd_done_q <= 1'b0;
    end else begin
      cmd_done_q <= cmd_done_nxt;
      if (accept) begin
        cur_addr  <= bus.cmd_addr;
        remaining <= bus.cmd_len;
      end else if (beat_ok) begin
        cur_addr  <= cur_addr + 24'd1;
        remaining <= remaining_upd;
        beats     <= beats + 8'd1;
      end
      if (mem_req && bus.mem_ready) begin
        beats   <= '0;
        req_len <= chunk;
      end
    end
  end

  // FIFO pointers and occupancy; abort empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (beat_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(beat_ok) - CW'(pop);
    end
  end

  // FIFO storage: {last word of command, data}.
  always_ff @(posedge clk) begin
    if (beat_ok) fifo_mem[wr_ptr] <= {remaining == 16'd1, bus.mem_rdata_16};
  end

`ifndef SYNTHESIS
  // The controller must never deliver more beats than were requested.
  always_ff @(posedge clk) begin
    if (rst_n && state == XFER && bus.mem_burst_data_valid && !bus.abort)
      assert (beats < req_len);
  end
`endif

  assign bus.cmd_ready     = cmd_ready;
  assign bus.cmd_done      = cmd_done_q;
  assign bus.busy          = (state != IDLE);
  assign bus.out_valid     = (count != '0);
  assign bus.out_data      = (count != '0) ? fifo_mem[rd_ptr][15:0] : 16'd0;
  assign bus.out_last      = (count != '0) ? fifo_mem[rd_ptr][16] : 1'b0;
  assign bus.mem_req       = mem_req;
  assign bus.mem_we        = 1'b0;
  assign bus.mem_addr      = (state == REQ) ? cur_addr : 24'd0;
  assign bus.mem_burst_len = (state == REQ) ? chunk : 8'd0;

endmodule

// File: tb/tb_sram_burst_reader.sv
// Bench for sram_burst_reader: a randomized SRAM responder and consumer run
// on the falling edge; the directed sequence drives commands just after the
// rising edge and compares against a word/request model of each command.
module tb_sram_burst_reader;
  logic clk, rst_n;
  sram_burst_reader_if bus ();

  sram_burst_reader #(.MAX_BURST(255), .FIFO_DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_assert = 0, n_fail = 0;
  logic [16:0] exp_q[$];
  logic [23:0] exp_a[$], req_a_q[$];
  int exp_l[$], req_l_q[$];
  int occ = 0, done_cnt = 0, cancel_beats = 0, d_start = 0;
  bit hold_ready = 0, dropping = 0, r_active = 0;
  logic [23:0] r_addr;
  int r_len = 0, r_sent = 0, r_stop = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] word_at(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'h5A3C;
  endfunction

  // Expected words and bursts: chunks of min(left, 255); the first burst may
  // be cut short after k beats, in which case the rest is requested again.
  task automatic build_model(input logic [23:0] a, input int len, input int k);
    int pos, c, d;
    bit first;
    exp_a.delete();
    exp_l.delete();
    for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, word_at(24'(a + i))});
    pos = 0;
    first = 1;
    while (pos < len) begin
      c = (len - pos > 255) ? 255 : len - pos;
      exp_a.push_back(24'(a + pos));
      exp_l.push_back(c);
      d = (first && k != 0) ? k : c;
      pos += d;
      first = 0;
    end
  endtask

  task automatic issue_cmd(input logic [23:0] a, input int len, input int k);
    build_model(a, len, k);
    req_a_q.delete();
    req_l_q.delete();
    cancel_beats = k;
    d_start = done_cnt;
    bus.cmd_valid = 1;
    bus.cmd_addr = a;
    bus.cmd_len = 16'(len);
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 0;
  endtask

  task automatic finish_cmd();
    int b;
    b = 20000;
    while ((done_cnt == d_start || exp_q.size() != 0 || r_active) && b > 0) begin
      tick();
      b--;
    end
    chk("cmd_complete", b > 0, 1);
    repeat (3) tick();
    chk("cmd_done_once", done_cnt - d_start, 1);
    chk("req_count", req_a_q.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < req_a_q.size(); i++) begin
      chk("req_addr", req_a_q[i], exp_a[i]);
      chk("req_len", req_l_q[i], exp_l[i]);
    end
    chk("idle_after_cmd", bus.busy, 0);
  endtask

  // SRAM controller: random accept delay, random beat gaps, optional cancel.
  initial begin
    bus.mem_ready = 0;
    bus.mem_burst_data_valid = 0;
    bus.mem_rdata_16 = '0;
    bus.mem_burst_done = 0;
    forever begin
      @(negedge clk);
      bus.mem_burst_data_valid = 0;
      bus.mem_burst_done = 0;
      if (!r_active) begin
        bus.mem_ready = ($urandom_range(3) != 0);
        if (rst_n && bus.mem_req && bus.mem_ready) begin
          r_active = 1;
          r_addr = bus.mem_addr;
          r_len = int'(bus.mem_burst_len);
          r_sent = 0;
          r_stop = (cancel_beats != 0) ? cancel_beats : r_len;
          cancel_beats = 0;
          req_a_q.push_back(r_addr);
          req_l_q.push_back(r_len);
          chk("grant_space", (256 - occ) >= r_len, 1);
        end
      end else begin
        bus.mem_ready = 0;
        if (r_sent < r_stop && $urandom_range(3) != 0) begin
          bus.mem_burst_data_valid = 1;
          bus.mem_rdata_16 = word_at(24'(r_addr + r_sent));
          r_sent++;
          if (!dropping) occ++;
        end
        if (r_sent == r_stop && (!bus.mem_burst_data_valid || $urandom_range(1) == 0)) begin
          bus.mem_burst_done = 1;
          r_active = 0;
        end
      end
    end
  end

  // Consumer: random back-pressure, checks every popped word in order.
  initial begin
    logic [16:0] e;
    bus.out_ready = 0;
    forever begin
      @(negedge clk);
      bus.out_ready = !hold_ready && ($urandom_range(3) != 0);
      if (rst_n && bus.cmd_done) done_cnt++;
      if (rst_n && !bus.abort && bus.out_valid && bus.out_ready) begin
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_data", bus.out_data, e[15:0]);
          chk("out_last", bus.out_last, e[16]);
        end
        if (occ > 0) occ--;
      end
    end
  end

  initial begin
    int b, len, k, c1;
    logic [23:0] a;
    rst_n = 0;
    bus.cmd_valid = 0;
    bus.cmd_addr = '0;
    bus.cmd_len = '0;
    bus.abort = 0;
    repeat (3) tick();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_cmd_done", bus.cmd_done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_len", bus.mem_burst_len, 0);
    chk("mem_we_zero", bus.mem_we, 0);
    rst_n = 1;
    tick();

    // Short command with request latency checks.
    issue_cmd(24'h000100, 4, 0);
    chk("lat1_busy", bus.busy, 1);
    chk("lat1_cmd_ready", bus.cmd_ready, 0);
    chk("lat1_no_req", bus.mem_req, 0);
    tick();
    chk("lat2_req", bus.mem_req, 1);
    chk("lat2_addr", bus.mem_addr, 24'h000100);
    chk("lat2_len", bus.mem_burst_len, 4);
    finish_cmd();

    // Multi-burst command.
    issue_cmd(24'h000000, 600, 0);
    finish_cmd();

    // First burst cancelled after 10 beats.
    issue_cmd(24'($urandom), 255, 10);
    finish_cmd();

    // Consumer stalled: second burst must wait for FIFO space.
    hold_ready = 1;
    issue_cmd(24'h012300, 300, 0);
    b = 3000;
    while (!(occ == 255 && !r_active) && b > 0) begin
      tick();
      b--;
    end
    chk("stall_first_burst", b > 0, 1);
    repeat (60) tick();
    chk("stall_req_count", req_a_q.size(), 1);
    chk("stall_out_valid", bus.out_valid, 1);
    chk("stall_no_req", bus.mem_req, 0);
    chk("stall_busy", bus.busy, 1);
    hold_ready = 0;
    finish_cmd();

    // Zero-length command.
    req_a_q.delete();
    d_start = done_cnt;
    bus.cmd_valid = 1;
    bus.cmd_addr = 24'h00ABCD;
    bus.cmd_len = 16'd0;
    tick();
    bus.cmd_valid = 0;
    chk("len0_done", bus.cmd_done, 1);
    chk("len0_busy", bus.busy, 0);
    chk("len0_no_req", bus.mem_req, 0);
    tick();
    chk("len0_done_pulse", bus.cmd_done, 0);
    repeat (5) tick();
    chk("len0_req_count", req_a_q.size(), 0);
    chk("len0_out_valid", bus.out_valid, 0);
    chk("len0_done_count", done_cnt - d_start, 1);

    // Abort at beat 5.
    issue_cmd(24'($urandom), 255, 0);
    b = 3000;
    while (!(r_active && r_sent >= 5) && b > 0) begin
      tick();
      b--;
    end
    chk("abort_reach_beat5", b > 0, 1);
    bus.abort = 1;
    tick();
    bus.abort = 0;
    exp_q.delete();
    occ = 0;
    dropping = 1;
    chk("abort_cmd_ready", bus.cmd_ready, 0);
    chk("abort_busy", bus.busy, 1);
    chk("abort_fifo_empty", bus.out_valid, 0);
    chk("abort_no_req", bus.mem_req, 0);
    b = 3000;
    while (r_active && b > 0) begin
      tick();
      b--;
    end
    chk("abort_burst_end", b > 0, 1);
    tick();
    chk("abort_idle_ready", bus.cmd_ready, 1);
    chk("abort_idle_busy", bus.busy, 0);
    repeat (20) tick();
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_req_count", req_a_q.size(), 1);
    chk("abort_no_done", done_cnt - d_start, 0);
    dropping = 0;

    // Reset in the middle of a burst.
    issue_cmd(24'($urandom), 100, 0);
    b = 3000;
    while (!(r_active && r_sent >= 3) && b > 0) begin
      tick();
      b--;
    end
    chk("rst_reach_xfer", b > 0, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_last", bus.out_last, 0);
    chk("mid_rst_mem_req", bus.mem_req, 0);
    chk("mid_rst_mem_addr", bus.mem_addr, 0);
    chk("mid_rst_mem_len", bus.mem_burst_len, 0);
    chk("mid_rst_cmd_done", bus.cmd_done, 0);
    dropping = 1;
    exp_q.delete();
    occ = 0;
    tick();
    tick();
    rst_n = 1;
    b = 3000;
    while (r_active && b > 0) begin
      tick();
      b--;
    end
    tick();
    chk("post_rst_out_valid", bus.out_valid, 0);
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_req_count", req_a_q.size(), 1);
    dropping = 0;

    // Random commands, including one crossing the top of the address space.
    for (int n = 0; n < 5; n++) begin
      a = (n == 0) ? 24'hFFFF00 + 24'($urandom_range(255)) : 24'($urandom);
      len = $urandom_range(1, 700);
      c1 = (len > 255) ? 255 : len;
      k = ($urandom_range(1) == 0) ? $urandom_range(1, c1) : 0;
      issue_cmd(a, len, k);
      finish_cmd();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
